register_file_read: RTL

- Read side of the multi-cycle ARM register file: 15 general registers (R0-R14) with one write port and two read ports.
- The read ports are registered, acting as the A/B operand latches of the multi-cycle datapath.
- R15 reads return the externally supplied PC+8 value.
- Sits between the decode stage (supplies read addresses) and the ALU operand muxes; the writeback stage drives the write port.

---
 rtl/register_file_read_if.sv | 26 ++
 rtl/register_file_read.sv | 77 +++++++
 2 files changed

// File: rtl/register_file_read_if.sv
// Bus bundle between the decode/writeback stages and the registered register-file read ports.
interface register_file_read_if #(
  parameter int unsigned width  = 32,
  parameter int unsigned addr_w = 4
);
  logic [addr_w-1:0] RA1;
  logic [addr_w-1:0] RA2;
  logic              read;
  logic [addr_w-1:0] WA3;
  logic [width-1:0]  WD3;
  logic              write;
  logic [width-1:0]  R15;
  logic [width-1:0]  RD1;
  logic [width-1:0]  RD2;
  logic              valid;

  modport master (
    output RA1, RA2, read, WA3, WD3, write, R15,
    input  RD1, RD2, valid
  );

  modport slave (
    input  RA1, RA2, read, WA3, WD3, write, R15,
    output RD1, RD2, valid
  );
endinterface

// File: rtl/register_file_read.sv
// Register file (R0-R14) with one write port and two registered read ports acting as the
// A/B operand latches; address 15 returns the externally supplied PC+8.
module register_file_read #(
  parameter int unsigned width  = 32,
  parameter int unsigned addr_w = 4
) (
  input  logic                clk,
  input  logic                reset,
  register_file_read_if.slave bus
);

  localparam int unsigned      NumRegs = (2 ** addr_w) - 1;
  localparam logic [addr_w-1:0] PcAddr = '1;

  logic [width-1:0] regs_q [NumRegs];
  logic [width-1:0] rd1_q, rd1_d;
  logic [width-1:0] rd2_q, rd2_d;
  logic             valid_q, valid_d;

  // Operand selection: PC+8 wins, then same-edge write forwarding, then storage.
  always_comb begin
    rd1_d = rd1_q;
    if (bus.read) begin
      if (bus.RA1 == PcAddr) begin
        rd1_d = bus.R15;
      end else if (bus.write && (bus.WA3 == bus.RA1)) begin
        rd1_d = bus.WD3;
      end else begin
        rd1_d = regs_q[bus.RA1];
      end
    end
  end

  always_comb begin
    rd2_d = rd2_q;
    if (bus.read) begin
      if (bus.RA2 == PcAddr) begin
        rd2_d = bus.R15;
      end else if (bus.write && (bus.WA3 == bus.RA2)) begin
        rd2_d = bus.WD3;
      end else begin
        rd2_d = regs_q[bus.RA2];
      end
    end
  end

  always_comb begin
    valid_d = bus.read;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.write && (bus.WA3 != PcAddr)) begin
      regs_q[bus.WA3] <= bus.WD3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd1_q   <= '0;
      rd2_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      valid_q <= valid_d;
    end
  end

  assign bus.RD1   = rd1_q;
  assign bus.RD2   = rd2_q;
  assign bus.valid = valid_q;

endmodule
